// File: rtl/line_mem.sv
// line_mem: line-granular backing store sitting below the cache's lower-level
// port. Read and write-back requests are queued in order, each is serviced a
// fixed LATENCY after reaching the queue head, and read data comes back as one
// full line. Writes are posted and produce no response.
//
// Optional feature: define LINE_MEM_STATS_EN to add saturating read/write
// completion counters (rd_count_out, wr_count_out).
//
// Handshake rule (both directions): a transfer happens on the rising edge
// where valid & ready are both 1. A source holds valid and its payload stable
// until that edge. hc_ready_out is a function of queue state only and never
// looks at hc_valid_in.
//
// Ports:
//   clk_in         clock, all state on rising edge
//   rst_N_in       asynchronous active-low reset
//   hc_valid_in    request valid
//   hc_ready_out   request queue can accept
//   hc_addr_in     request byte address
//   hc_value_in    write-back line data
//   hc_we_in       1 = write line, 0 = read line
//   hc_valid_out   read response valid
//   hc_ready_in    cache accepts the response
//   hc_addr_out    line-aligned address of the response
//   hc_value_out   read line data
//   rd_count_out   completed read responses (LINE_MEM_STATS_EN only)
//   wr_count_out   committed writes (LINE_MEM_STATS_EN only)
//   dbg_state_out  engine state: 0 IDLE, 1 BUSY, 2 RESP
module line_mem #(
  parameter int W         = 64,
  parameter int LINE_BITS = 512,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 4,
  parameter int QDEPTH    = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  input  logic                 hc_valid_in,
  output logic                 hc_ready_out,
  input  logic [W-1:0]         hc_addr_in,
  input  logic [LINE_BITS-1:0] hc_value_in,
  input  logic                 hc_we_in,
  output logic                 hc_valid_out,
  input  logic                 hc_ready_in,
  output logic [W-1:0]         hc_addr_out,
  output logic [LINE_BITS-1:0] hc_value_out,
`ifdef LINE_MEM_STATS_EN
  output logic [31:0]          rd_count_out,
  output logic [31:0]          wr_count_out,
`endif
  output logic [1:0]           dbg_state_out
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int QP_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int QC_W  = $clog2(QDEPTH + 1);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);
  localparam logic [QC_W-1:0]  Q_FULL   = QC_W'(QDEPTH);
  localparam logic [W-1:0]     OFS_MASK = W'(63);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state;
  logic [LAT_W-1:0]       lat_cnt;

  // Request queue: circular buffer, the head entry stays in place while it is
  // being serviced and is popped only when its service completes.
  logic                   q_we   [QDEPTH];
  logic [IDX_W-1:0]       q_idx  [QDEPTH];
  logic [W-1:0]           q_addr [QDEPTH];
  logic [LINE_BITS-1:0]   q_data [QDEPTH];
  logic [QP_W-1:0]        wr_ptr;
  logic [QP_W-1:0]        rd_ptr;
  logic [QC_W-1:0]        q_count;

  // Line storage; deliberately not reset.
  logic [LINE_BITS-1:0]   mem [DEPTH];

  logic accept;
  logic at_zero;
  logic commit;
  logic resp_done;
  logic pop;

  function automatic logic [QP_W-1:0] ptr_inc(input logic [QP_W-1:0] p);
    return (p == QP_W'(QDEPTH - 1)) ? '0 : p + QP_W'(1);
  endfunction

  // Full means not ready even if the head pops on this same edge; the freed
  // slot shows up one cycle later.
  assign hc_ready_out  = (q_count < Q_FULL);
  assign accept        = hc_valid_in & hc_ready_out;
  assign at_zero       = (state == ST_BUSY) && (lat_cnt == '0);
  assign commit        = at_zero & q_we[rd_ptr];
  assign resp_done     = (state == ST_RESP) & hc_valid_out & hc_ready_in;
  assign pop           = commit | resp_done;
  assign dbg_state_out = state;

  // Queue payload and line storage writes (no reset on data arrays).
  always_ff @(posedge clk_in) begin
    if (accept) begin
      q_we[wr_ptr]   <= hc_we_in;
      q_idx[wr_ptr]  <= hc_addr_in[6 +: IDX_W];
      q_addr[wr_ptr] <= hc_addr_in & ~OFS_MASK;
      q_data[wr_ptr] <= hc_value_in;
    end
    if (commit) begin
      mem[q_idx[rd_ptr]] <= q_data[rd_ptr];
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, pop})
        2'b10:   q_count <= q_count + QC_W'(1);
        2'b01:   q_count <= q_count - QC_W'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Service engine. IDLE spends one cycle loading the counter, BUSY counts
  // down to zero and acts on the following edge, which gives the
  // accept-to-complete distance of 1 + LATENCY edges.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state        <= ST_IDLE;
      lat_cnt      <= '0;
      hc_valid_out <= 1'b0;
      hc_addr_out  <= '0;
      hc_value_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (q_count != '0) begin
            lat_cnt <= LAT_LOAD;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else if (q_we[rd_ptr]) begin
            state <= ST_IDLE;
          end else begin
            hc_value_out <= mem[q_idx[rd_ptr]];
            hc_addr_out  <= q_addr[rd_ptr];
            hc_valid_out <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (hc_ready_in) begin
            hc_valid_out <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LINE_MEM_STATS_EN
  // Saturating completion counters.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      rd_count_out <= '0;
      wr_count_out <= '0;
    end else begin
      if (resp_done && (rd_count_out != 32'hFFFF_FFFF))
        rd_count_out <= rd_count_out + 32'd1;
      if (commit && (wr_count_out != 32'hFFFF_FFFF))
        wr_count_out <= wr_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_mem.sv
module tb_line_mem;

  localparam int AW = 64;
  localparam int LB = 512;

  // ---------------- clock / reset block ----------------
  logic          clk_in = 1'b0;
  logic          rst_N_in;
  logic          hc_valid_in;
  logic          hc_ready_out;
  logic [AW-1:0] hc_addr_in;
  logic [LB-1:0] hc_value_in;
  logic          hc_we_in;
  logic          hc_valid_out;
  logic          hc_ready_in;
  logic [AW-1:0] hc_addr_out;
  logic [LB-1:0] hc_value_out;
  logic [1:0]    dbg_state_out;
`ifdef LINE_MEM_STATS_EN
  logic [31:0]   rd_count_out;
  logic [31:0]   wr_count_out;
`endif

  always #5 clk_in = ~clk_in;

  line_mem dut (
    .clk_in        (clk_in),
    .rst_N_in      (rst_N_in),
    .hc_valid_in   (hc_valid_in),
    .hc_ready_out  (hc_ready_out),
    .hc_addr_in    (hc_addr_in),
    .hc_value_in   (hc_value_in),
    .hc_we_in      (hc_we_in),
    .hc_valid_out  (hc_valid_out),
    .hc_ready_in   (hc_ready_in),
    .hc_addr_out   (hc_addr_out),
    .hc_value_out  (hc_value_out),
`ifdef LINE_MEM_STATS_EN
    .rd_count_out  (rd_count_out),
    .wr_count_out  (wr_count_out),
`endif
    .dbg_state_out (dbg_state_out)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [LB-1:0] model_mem [1024];
  logic [AW-1:0] exp_addr_q[$];
  logic [LB-1:0] exp_q[$];
  logic [LB-1:0] got_q[$];
  logic [9:0]    mdl_idx;
  logic          stall_prev = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [LB-1:0] prev_val;

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: because service is strictly in order with one engine, a
  // read's data is the line as left by every earlier-accepted write. So the
  // expected response is fixed at acceptance time.
  always @(negedge clk_in) begin
    if (!rst_N_in) begin
      exp_addr_q.delete();
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", hc_valid_out, 1);
        chk("hold_addr", hc_addr_out, prev_addr);
        chk("hold_value", hc_value_out, prev_val);
      end
      if (hc_valid_in && hc_ready_out) begin
        mdl_idx = hc_addr_in[6 +: 10];
        if (hc_we_in) begin
          model_mem[mdl_idx] = hc_value_in;
        end else begin
          exp_addr_q.push_back(hc_addr_in & ~64'h3F);
          exp_q.push_back(model_mem[mdl_idx]);
        end
      end
      if (hc_valid_out && hc_ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got addr %0h with no pending read", hc_addr_out);
        end else begin
          chk("resp_addr", hc_addr_out, exp_addr_q.pop_front());
          chk("resp_value", hc_value_out, exp_q.pop_front());
          got_q.push_back(hc_value_out);
        end
      end
      stall_prev = hc_valid_out && !hc_ready_in;
      prev_addr  = hc_addr_out;
      prev_val   = hc_value_out;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [LB-1:0] data);
    int  n    = 0;
    bit  done = 0;
    hc_valid_in = 1'b1;
    hc_we_in    = we;
    hc_addr_in  = addr;
    hc_value_in = data;
    while (!done && n < 50) begin
      @(negedge clk_in);
      if (hc_ready_out) done = 1;
      @(posedge clk_in);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: addr %0h never accepted", addr);
    end
    hc_valid_in = 1'b0;
  endtask

  task automatic wait_resp(input string name, input logic [AW-1:0] ea, input logic [LB-1:0] ev);
    int n = 0;
    @(negedge clk_in);
    while (!hc_valid_out && n < 40) begin
      @(posedge clk_in);
      @(negedge clk_in);
      n++;
    end
    chk({name, "_valid"}, hc_valid_out, 1);
    chk({name, "_addr"}, hc_addr_out, ea);
    chk({name, "_value"}, hc_value_out, ev);
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk_in);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses missing", exp_q.size());
    end
    idle(8);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_N_in    = 1'b0;
    hc_valid_in = 1'b0;
    hc_we_in    = 1'b0;
    hc_addr_in  = '0;
    hc_value_in = '0;
    hc_ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 rst_N_in = 1'b1;

    @(negedge clk_in);
    chk("rst_valid", hc_valid_out, 0);
    chk("rst_addr", hc_addr_out, 0);
    chk("rst_value", hc_value_out, 0);
    chk("rst_ready", hc_ready_out, 1);
    @(posedge clk_in);
    #1;

    // 1: write then read line 0, response exactly LATENCY+1 edges after accept
    send(1'b1, 64'h0, 512'h0123456789ABCDEF);
    idle(8);
    send(1'b0, 64'h0, '0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      chk($sformatf("t1_lat_edge%0d", k), hc_valid_out, (k == 5) ? 1 : 0);
    end
    chk("t1_addr", hc_addr_out, 0);
    chk("t1_value", hc_value_out, 512'h0123456789ABCDEF);
    @(posedge clk_in);
    #1;
    idle(2);
`ifdef LINE_MEM_STATS_EN
    chk("t1_rd_count", rd_count_out, 1);
    chk("t1_wr_count", wr_count_out, 1);
`endif

    // 2: unaligned read address returns the aligned line address
    send(1'b1, 64'h40, 512'hDEADBEEFDEADBEEF);
    send(1'b0, 64'h54, '0);
    wait_resp("t2", 64'h40, 512'hDEADBEEFDEADBEEF);
    idle(2);

    // 3: ordering around a write to the same line
    got_q.delete();
    send(1'b1, 64'h4000, 512'h0CAD456789AACDEF);
    send(1'b0, 64'h4000, '0);
    send(1'b1, 64'h4000, 512'hDEADBEEF12345678);
    send(1'b0, 64'h4000, '0);
    drain();
    chk("t3_nresp", got_q.size(), 2);
    chk("t3_first", got_q[0], 512'h0CAD456789AACDEF);
    chk("t3_second", got_q[1], 512'hDEADBEEF12345678);

    // 4: backpressure and full queue
    got_q.delete();
    hc_ready_in = 1'b0;
    send(1'b0, 64'h0, '0);
    send(1'b0, 64'h40, '0);
    hc_valid_in = 1'b1;
    hc_we_in    = 1'b0;
    hc_addr_in  = 64'h4000;
    @(negedge clk_in);
    chk("t4_full_ready", hc_ready_out, 0);
    begin
      int n = 0;
      while (!hc_valid_out && n < 20) begin
        @(posedge clk_in);
        @(negedge clk_in);
        n++;
      end
    end
    chk("t4_first_valid", hc_valid_out, 1);
    chk("t4_first_addr", hc_addr_out, 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      chk($sformatf("t4_stall%0d_value", k), hc_value_out, 512'h0123456789ABCDEF);
      chk($sformatf("t4_stall%0d_ready", k), hc_ready_out, 0);
    end
    @(posedge clk_in);
    #1 hc_ready_in = 1'b1;
    @(negedge clk_in);
    chk("t4_full_at_pop", hc_ready_out, 0);
    @(posedge clk_in);
    @(negedge clk_in);
    chk("t4_slot_free", hc_ready_out, 1);
    @(posedge clk_in);
    #1 hc_valid_in = 1'b0;
    drain();
    chk("t4_nresp", got_q.size(), 3);
    chk("t4_resp0", got_q[0], 512'h0123456789ABCDEF);
    chk("t4_resp1", got_q[1], 512'hDEADBEEFDEADBEEF);
    chk("t4_resp2", got_q[2], 512'hDEADBEEF12345678);

    // 5: addresses alias modulo DEPTH*64 bytes
    send(1'b1, 64'h10000, 512'hAA);
    send(1'b0, 64'h0, '0);
    wait_resp("t5", 64'h0, 512'hAA);
    idle(2);

    // 6: reset while a read is in service
    send(1'b0, 64'h40, '0);
    idle(2);
    rst_N_in = 1'b0;
    idle(2);
    rst_N_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      chk($sformatf("t6_quiet%0d", k), {hc_valid_out, hc_ready_out}, 2'b01);
    end
`ifdef LINE_MEM_STATS_EN
    chk("t6_rd_count", rd_count_out, 0);
    chk("t6_wr_count", wr_count_out, 0);
`endif
    @(posedge clk_in);
    #1;
    chk("end_no_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
